cyq_seq_tx: RTL and testbench

CYQ_SEQ_TX -- requirements
Module: cyq_seq_tx

---
 rtl/cyq_fsm_pkg.sv | 12 +
 rtl/cyq_seq_tx_if.sv | 19 +
 rtl/cyq_seq_mark.sv | 37 +++
 rtl/cyq_seq_tx.sv | 103 ++++++++++
 tb/tb_cyq_seq_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/cyq_fsm_pkg.sv
// Shared types and defaults for the cyq serial frame transmitter.
package cyq_fsm_pkg;

  localparam int unsigned CYQ_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cyq_state_e;

endpackage

// File: rtl/cyq_seq_tx_if.sv
// Frame request / serial output bundle for cyq_seq_tx.
interface cyq_seq_tx_if
  import cyq_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = CYQ_WIDTH_DEF
);

  logic             Start;
  logic [WIDTH-1:0] Data;
  logic             X;
  logic             Valid;
  logic             Busy;
  logic             Done;
  logic             Exp;

  modport master (output Start, Data, input X, Valid, Busy, Done, Exp);
  modport slave  (input Start, Data, output X, Valid, Busy, Done, Exp);

endinterface

// File: rtl/cyq_seq_mark.sv
// In-frame "011" detector: o_match is registered alongside the bit it completes.
module cyq_seq_mark (
  input  logic clk,
  input  logic rst_n,
  input  logic i_bit,
  input  logic i_valid,
  input  logic i_clear,
  output logic o_match
);

  logic [1:0] r_hist;
  logic [1:0] r_fill;
  logic [1:0] w_hist;
  logic [1:0] w_fill;

  // A clear coinciding with the first bit of a frame starts from empty history.
  assign w_hist = i_clear ? 2'b00 : r_hist;
  assign w_fill = i_clear ? 2'd0  : r_fill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist  <= 2'b00;
      r_fill  <= 2'd0;
      o_match <= 1'b0;
    end else begin
      o_match <= i_valid && (w_fill == 2'd2) && (w_hist == 2'b01) && i_bit;
      if (i_valid) begin
        r_hist <= {w_hist[0], i_bit};
        r_fill <= (w_fill == 2'd2) ? 2'd2 : w_fill + 2'd1;
      end else begin
        r_hist <= w_hist;
        r_fill <= w_fill;
      end
    end
  end

endmodule

// File: rtl/cyq_seq_tx.sv
// Serial frame transmitter: sends WIDTH bits MSB first, then a Done pulse,
// with a registered "011" marker aligned to X.
module cyq_seq_tx
  import cyq_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = CYQ_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  output logic             X,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic             Exp
);

  localparam int unsigned CW = $clog2(WIDTH);

  cyq_state_e       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_x;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_start;
  logic w_more;
  logic w_load;
  logic w_bit;

  // w_load marks every edge that places a frame bit onto X.
  assign w_start = (r_state == IDLE) && Start;
  assign w_more  = (r_state == SHIFT) && (r_cnt != CW'(WIDTH - 1));
  assign w_load  = w_start || w_more;
  assign w_bit   = w_start ? Data[WIDTH-1] : r_sh[WIDTH-1];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= SHIFT;
            r_sh    <= {Data[WIDTH-2:0], 1'b0};
            r_cnt   <= '0;
            r_x     <= w_bit;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_more) begin
            r_cnt <= r_cnt + CW'(1);
            r_x   <= w_bit;
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
          end else begin
            r_state <= DONE;
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_x     <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  cyq_seq_mark u_mark (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_bit   (w_bit),
    .i_valid (w_load),
    .i_clear (w_start),
    .o_match (Exp)
  );

  assign X     = r_x;
  assign Valid = r_valid;
  assign Busy  = r_busy;
  assign Done  = r_done;

endmodule

// File: tb/tb_cyq_seq_tx.sv
// Self-checking bench for cyq_seq_tx (WIDTH=8).
module tb_cyq_seq_tx;

  logic Clk;
  logic Rst;
  int   n_checks;
  int   n_fail;

  cyq_seq_tx_if #(.WIDTH(8)) bus ();

  cyq_seq_tx #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (bus.Start),
    .Data  (bus.Data),
    .X     (bus.X),
    .Valid (bus.Valid),
    .Busy  (bus.Busy),
    .Done  (bus.Done),
    .Exp   (bus.Exp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: frame bit i (0 = first sent) completes 0,1,1 with bits i-2, i-1.
  function automatic logic [7:0] ref_mask(input logic [7:0] d);
    logic [7:0] m;
    logic       b [8];
    m = '0;
    for (int i = 0; i < 8; i++) b[i] = d[7-i];
    for (int i = 2; i < 8; i++)
      if (!b[i-2] && b[i-1] && b[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_x"},     16'(bus.X),     16'd0);
    chk({tag, "_valid"}, 16'(bus.Valid), 16'd0);
    chk({tag, "_busy"},  16'(bus.Busy),  16'd0);
    chk({tag, "_done"},  16'(bus.Done),  16'd0);
    chk({tag, "_exp"},   16'(bus.Exp),   16'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [7:0] m, input string tag,
                           input bit disturb);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Data  = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (i == 0) bus.Start = 1'b0;
      if (disturb && i == 3) begin
        bus.Data  = ~d;
        bus.Start = 1'b1;
      end
      if (disturb && i == 5) bus.Start = 1'b0;
      chk($sformatf("%s_x%0d", tag, i),     16'(bus.X),     16'(d[7-i]));
      chk($sformatf("%s_valid%0d", tag, i), 16'(bus.Valid), 16'd1);
      chk($sformatf("%s_busy%0d", tag, i),  16'(bus.Busy),  16'd1);
      chk($sformatf("%s_done%0d", tag, i),  16'(bus.Done),  16'd0);
      chk($sformatf("%s_exp%0d", tag, i),   16'(bus.Exp),   16'(m[i]));
    end
    @(negedge Clk);
    chk({tag, "_done_pulse"}, 16'(bus.Done),  16'd1);
    chk({tag, "_done_valid"}, 16'(bus.Valid), 16'd0);
    chk({tag, "_done_x"},     16'(bus.X),     16'd0);
    chk({tag, "_done_exp"},   16'(bus.Exp),   16'd0);
    chk({tag, "_done_busy"},  16'(bus.Busy),  16'd1);
    @(negedge Clk);
    chk_idle({tag, "_after"});
    if (disturb) begin
      repeat (3) begin
        @(negedge Clk);
        chk_idle({tag, "_noqueue"});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl [8];
    logic [7:0] d;
    logic [7:0] m;
    int         p;

    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{8'h6C, 8'h24};
    tbl[1] = '{8'hFF, 8'h00};
    tbl[2] = '{8'h00, 8'h00};
    tbl[3] = '{8'h33, 8'h88};
    tbl[4] = '{8'h7F, 8'h04};
    tbl[5] = '{8'h5B, 8'h90};
    tbl[6] = '{8'hDB, 8'h90};
    tbl[7] = '{8'h60, 8'h04};

    // Reset with Start high: the request must be discarded.
    Rst       = 1'b0;
    bus.Start = 1'b1;
    bus.Data  = 8'hFF;
    repeat (3) @(negedge Clk);
    chk_idle("reset");
    Rst       = 1'b1;
    bus.Start = 1'b0;
    @(negedge Clk);
    chk_idle("reset_start_discard");

    for (int v = 0; v < 8; v++)
      run_frame(tbl[v].data, tbl[v].mask, $sformatf("tbl%0d", v), 1'b0);

    // Start held high: period of 10 cycles with a single idle cycle.
    @(negedge Clk);
    d         = 8'h33;
    m         = ref_mask(d);
    bus.Start = 1'b1;
    bus.Data  = d;
    for (int t = 1; t <= 30; t++) begin
      @(negedge Clk);
      p = (t - 1) % 10;
      if (t == 30) bus.Start = 1'b0;
      chk($sformatf("held_valid%0d", t), 16'(bus.Valid), 16'(p < 8));
      chk($sformatf("held_x%0d", t),     16'(bus.X),     (p < 8) ? 16'(d[7-p]) : 16'd0);
      chk($sformatf("held_exp%0d", t),   16'(bus.Exp),   (p < 8) ? 16'(m[p]) : 16'd0);
      chk($sformatf("held_done%0d", t),  16'(bus.Done),  16'(p == 8));
      chk($sformatf("held_busy%0d", t),  16'(bus.Busy),  16'(p != 9));
    end
    @(negedge Clk);
    chk_idle("held_stop");

    // Reset sampled at edge k+4 aborts the frame without a Done pulse.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Data  = 8'h6C;
    repeat (4) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    Rst = 1'b0;
    @(negedge Clk);
    chk_idle("abort");
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk_idle("abort_quiet");
    end
    run_frame(8'h6C, 8'h24, "post_rst", 1'b0);

    run_frame(8'hA7, ref_mask(8'hA7), "disturb", 1'b1);

    for (int r = 0; r < 40; r++) begin
      d = 8'($urandom);
      run_frame(d, ref_mask(d), $sformatf("rnd%0d_%02h", r, d), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
